// File: rtl/puf_pkg.sv
// Shared definitions for the arbiter-PUF challenge/response controller:
// challenge width, LFSR feedback taps and the controller state encoding.
package puf_pkg;

    // Challenge width equals the arbiter mux-chain length; the LFSR fixes it at 8.
    localparam int C_LENGTH = 8;

    // Feedback taps for x^8+x^6+x^5+x^4+1: new bit = q[7]^q[5]^q[4]^q[3].
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // Value substituted for an all-zero seed, which would lock the LFSR.
    localparam logic [7:0] SEED_NONZERO = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_FIRE   = 3'd3,
        ST_NEXT   = 3'd4,
        ST_DONE   = 3'd5
    } puf_state_e;

endpackage

// File: rtl/puf_lfsr8.sv
// 8-bit Fibonacci LFSR producing the challenge sequence. Load wins over step.
module puf_lfsr8
    import puf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    // Shift left, feeding the XOR of the tapped bits into bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 8'h00;
        end else if (load) begin
            q <= seed;
        end else if (step) begin
            q <= {q[6:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/puf_crp_controller.sv
// Initiator side of the arbiter-PUF link: drives challenges from a seeded LFSR,
// fires the race pulse, majority-votes repeated 1-bit responses and assembles
// RESP_BITS voted bits into a word offered on a valid/ready handshake.
//
// Handshake: resp_valid rises when a word is complete and stays high, with
// resp_data and unstable_cnt frozen, until a clock edge where resp_valid and
// resp_ready are both high; that edge transfers the word and returns to IDLE.
// resp_ready is ignored whenever resp_valid is low.
module puf_crp_controller
    import puf_pkg::*;
#(
    parameter int RESP_BITS  = 16,
    parameter int VOTES      = 3,
    parameter int SETTLE_CYC = 4,
    parameter int PULSE_CYC  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           seed,
    output logic [C_LENGTH-1:0]  challenge,
    output logic                 puf_pulse,
    input  logic                 puf_response,
    output logic                 busy,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [RESP_BITS-1:0] resp_data,
    output logic [5:0]           unstable_cnt
);

    localparam int MAX_CYC = (SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC;
    localparam int CW      = $clog2(MAX_CYC);
    localparam int VW      = $clog2(VOTES + 1);
    localparam int BW      = $clog2(RESP_BITS);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYC - 1);
    localparam logic [VW-1:0] VOTES_V     = VW'(VOTES);
    localparam logic [VW-1:0] VOTE_LAST   = VW'(VOTES - 1);
    localparam logic [VW-1:0] VOTE_HALF   = VW'(VOTES / 2);
    localparam logic [BW-1:0] BIT_LAST    = BW'(RESP_BITS - 1);

    puf_state_e     state;
    logic [1:0]     sync;
    logic           resp_s;
    logic [CW-1:0]  cyc_cnt;
    logic [VW-1:0]  vote_cnt;
    logic [VW-1:0]  ones;
    logic [BW-1:0]  bit_cnt;
    logic           vote_bit;
    logic           split_vote;
    logic           lfsr_load;
    logic           lfsr_step;
    logic [7:0]     seed_eff;

    assign resp_s     = sync[1];
    assign vote_bit   = (ones > VOTE_HALF);
    assign split_vote = (ones != '0) && (ones != VOTES_V);
    assign seed_eff   = (seed == 8'h00) ? SEED_NONZERO : seed;
    assign lfsr_load  = (state == ST_LOAD);
    assign lfsr_step  = (state == ST_NEXT) && (bit_cnt != BIT_LAST);

    puf_lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .step (lfsr_step),
        .seed (seed_eff),
        .q    (challenge)
    );

    // Two-flop synchronizer for the asynchronous arbiter output.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], puf_response};
        end
    end

    // Controller FSM with its counters, vote accumulator and response shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            puf_pulse    <= 1'b0;
            busy         <= 1'b0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            unstable_cnt <= 6'd0;
            cyc_cnt      <= '0;
            vote_cnt     <= '0;
            ones         <= '0;
            bit_cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    resp_data    <= '0;
                    unstable_cnt <= 6'd0;
                    cyc_cnt      <= '0;
                    vote_cnt     <= '0;
                    ones         <= '0;
                    bit_cnt      <= '0;
                    state        <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cyc_cnt == SETTLE_LAST) begin
                        cyc_cnt   <= '0;
                        puf_pulse <= 1'b1;
                        state     <= ST_FIRE;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                ST_FIRE: begin
                    if (cyc_cnt == PULSE_LAST) begin
                        cyc_cnt   <= '0;
                        puf_pulse <= 1'b0;
                        ones      <= ones + VW'(resp_s);
                        vote_cnt  <= vote_cnt + 1'b1;
                        state     <= (vote_cnt == VOTE_LAST) ? ST_NEXT : ST_SETTLE;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                ST_NEXT: begin
                    resp_data    <= {resp_data[RESP_BITS-2:0], vote_bit};
                    unstable_cnt <= unstable_cnt + 6'(split_vote);
                    ones         <= '0;
                    vote_cnt     <= '0;
                    if (bit_cnt == BIT_LAST) begin
                        resp_valid <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_crp_controller.sv
// Directed bench for puf_crp_controller: PUF behaviour models, latency,
// handshake hold, mid-run reset, pulse width and challenge stability.
module tb_puf_crp_controller;

    localparam int RB  = 16;
    localparam int VT  = 3;
    localparam int PC  = 4;
    localparam int LAT = 401;

    logic          clk;
    logic          rst;
    logic          start;
    logic [7:0]    seed;
    logic [7:0]    challenge;
    logic          puf_pulse;
    logic          puf_response;
    logic          busy;
    logic          resp_valid;
    logic          resp_ready;
    logic [RB-1:0] resp_data;
    logic [5:0]    unstable_cnt;

    int checks = 0;
    int errors = 0;

    // PUF model: 0 = challenge[0], 1 = constant 1, 2 = constant 0, 3 = 1,0,1 per vote
    int         puf_mode = 0;
    logic [2:0] alt_pat  = 3'b101;
    int         alt_idx  = 0;
    logic       alt_val  = 1'b0;

    // monitor state
    int         pulse_idx   = 0;
    int         hi_cnt      = 0;
    logic       prev_pulse  = 1'b0;
    logic [7:0] prev_chal   = 8'h00;
    logic       abort_pulse = 1'b0;
    logic [7:0] chal_q[$];

    puf_crp_controller #(
        .RESP_BITS  (RB),
        .VOTES      (VT),
        .SETTLE_CYC (4),
        .PULSE_CYC  (PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .seed         (seed),
        .challenge    (challenge),
        .puf_pulse    (puf_pulse),
        .puf_response (puf_response),
        .busy         (busy),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .unstable_cnt (unstable_cnt)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    // expected word when the PUF answers challenge[0]
    function automatic logic [15:0] model_word(input logic [7:0] s);
        logic [7:0]  c;
        logic [15:0] w;
        c = (s == 8'h00) ? 8'h01 : s;
        w = 16'h0000;
        for (int b = 0; b < RB; b++) begin
            w = {w[14:0], c[0]};
            c = lfsr_next(c);
        end
        return w;
    endfunction

    // PUF response models
    always @* begin
        case (puf_mode)
            0:       puf_response = challenge[0];
            1:       puf_response = 1'b1;
            2:       puf_response = 1'b0;
            default: puf_response = alt_val;
        endcase
    end

    always @(posedge puf_pulse) begin
        if (puf_mode == 3) begin
            alt_val = alt_pat[alt_idx];
            alt_idx = (alt_idx + 1) % 3;
        end
    end

    // pulse width, challenge stability and per-bit challenge capture
    always @(negedge clk) begin
        if (puf_pulse && !prev_pulse) begin
            if (pulse_idx % VT == 0) chal_q.push_back(challenge);
            pulse_idx++;
        end
        if (puf_pulse && prev_pulse) check("chal_stable", 32'(challenge), 32'(prev_chal));
        if (puf_pulse) begin
            hi_cnt++;
        end else if (prev_pulse) begin
            if (!abort_pulse) check("pulse_width", hi_cnt, PC);
            hi_cnt = 0;
        end
        prev_pulse = puf_pulse;
        prev_chal  = challenge;
    end

    // driver tasks
    task automatic start_word(input logic [7:0] s);
        @(negedge clk);
        seed      = s;
        start     = 1'b1;
        pulse_idx = 0;
        chal_q.delete();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!resp_valid && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
        check("valid_timeout", 32'(resp_valid), 32'd1);
    endtask

    task automatic accept_word();
        @(negedge clk);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("accept_valid", 32'(resp_valid), 32'd0);
        check("accept_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_word(input string tag, input logic [7:0] s,
                            input logic [15:0] exp_data, input logic [5:0] exp_unst);
        int lat;
        start_word(s);
        wait_valid(lat);
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_data"}, 32'(resp_data), 32'(exp_data));
        check({tag, "_unstable"}, 32'(unstable_cnt), 32'(exp_unst));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_challenge"}, 32'(challenge), 32'd0);
        check({tag, "_pulse"}, 32'(puf_pulse), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_data"}, 32'(resp_data), 32'd0);
        check({tag, "_unstable"}, 32'(unstable_cnt), 32'd0);
    endtask

    initial begin
        logic [15:0] exp_q[$];
        logic [7:0]  exp_chal[5];
        int          lat;
        int          guard;

        rst        = 1'b1;
        start      = 1'b0;
        seed       = 8'h00;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // 1: seed 00 -> 01, PUF = challenge[0]
        exp_chal = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
        puf_mode = 0;
        exp_q.push_back(model_word(8'h00));
        run_word("lfsr", 8'h00, exp_q.pop_front(), 6'd0);
        check("lfsr_msb5", 32'(resp_data[15:11]), 32'b10001);
        check("chal_count", chal_q.size(), RB);
        for (int i = 0; i < 5; i++) begin
            if (i < chal_q.size()) check($sformatf("chal_%0d", i), 32'(chal_q[i]), 32'(exp_chal[i]));
        end
        accept_word();

        // 2: constant responses
        puf_mode = 1;
        run_word("const1", 8'h3C, 16'hFFFF, 6'd0);
        accept_word();
        puf_mode = 2;
        run_word("const0", 8'h3C, 16'h0000, 6'd0);
        accept_word();

        // 3: 1,0,1 per vote on every bit -> majority 1, every bit split
        puf_mode = 3;
        alt_idx  = 0;
        run_word("alt", 8'hA5, 16'hFFFF, 6'd16);

        // 4: hold off acceptance, try to restart meanwhile
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            start = (i == 10 || i == 11);
            if (i % 10 == 5) begin
                check("hold_data", 32'(resp_data), 32'hFFFF);
                check("hold_valid", 32'(resp_valid), 32'd1);
                check("hold_unstable", 32'(unstable_cnt), 32'd16);
            end
        end
        @(negedge clk);
        resp_ready = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        start      = 1'b0;
        check("hs_valid", 32'(resp_valid), 32'd0);
        check("hs_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("hs_no_restart", 32'(busy), 32'd0);

        // 5: reset during FIRE of bit 5, then a fresh full word
        puf_mode = 0;
        start_word(8'h5A);
        guard = 0;
        while (pulse_idx < 5 * VT + 1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("bit5_reached", 32'(guard < 1000), 32'd1);
        check("bit5_pulse", 32'(puf_pulse), 32'd1);
        abort_pulse = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort_pulse = 1'b0;
        run_word("fresh", 8'h5A, model_word(8'h5A), 6'd0);
        accept_word();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
